tx_tlp_header_insertion: RTL and testbench
==========================================

TX_TLP_HEADER_INSERTION -- requirements
Module: tx_tlp_header_insertion

Interface
REQ-001 SHALL have parameter PCIE_DATA_WIDTH, default 256, PCIe-side beat width; only 256 is supported.
REQ-002 SHALL have parameter NVME_DATA_WIDTH, default 256, NVMe-side beat width; must equal PCIE_DATA_WIDTH.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-004 SHALL have port rstn, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port srst, input, 1, synchronous active-high reset.
REQ-006 SHALL have ports hdr_valid (input, 1), hdr_data (input, 96, 3-DW TLP header, DW0 in [31:0]), hdr_nodata (input, 1, header-only TLP) and hdr_ready (output, 1).
REQ-007 SHALL have ports in_valid, in_sof, in_eof (input, 1 each), in_byte (input, 4, valid DW count 1..8, meaningful on eof only, else 8), in_be (input, 32), in_data (input, 256) and in_ready (output, 1).
REQ-008 SHALL have ports out_valid, out_sof, out_eof (output, 1 each), out_byte (output, 4, valid DW count), out_be (output, 32), out_data (output, 256) and out_ready (input, 1).

Function
REQ-009 SHALL register all out_* signals; adv = ~out_valid | out_ready; out_* change only when adv=1.
REQ-010 SHALL transfer on hdr_valid&hdr_ready, on in_valid&in_ready and on out_valid&out_ready; latency 1 cycle from an input transfer to out_valid.
REQ-011 SHALL implement the states IDLE, BODY and TAIL, holding a carry register of 3 DW (96 bits of data, 12 bits of be) plus carry_cnt (0..3).
REQ-012 IDLE, hdr_nodata=1: hdr_ready=adv, in_ready=0; on accept, the output beat SHALL be data={160'b0,hdr_data}, be=32'h00000FFF, byte=3, sof=eof=1; the state SHALL stay IDLE.
REQ-013 IDLE, hdr_nodata=0: hdr_ready=in_ready=adv&hdr_valid&in_valid&in_sof; header and first data beat SHALL be accepted in the same cycle; otherwise both SHALL be held (not popped).
REQ-014 First beat: data={in_data[159:0],hdr_data}, be={in_be[19:0],12'hFFF}, sof=1; carry<=in_data[255:160], in_be[31:20].
REQ-015 Subsequent BODY beat: in_ready=adv; data={in_data[159:0],carry}, be={in_be[19:0],carry_be}, sof=0; carry updated as in REQ-014.
REQ-016 On an accepted beat with in_eof=0: out_byte=8, eof=0, next state BODY.
REQ-017 On an accepted beat with in_eof=1 and n=in_byte<=5: out_byte=n+3, eof=1, next state IDLE; be bits above DW (n+3) SHALL be forced 0.
REQ-018 On an accepted beat with in_eof=1 and n>5: out_byte=8, eof=0, carry_cnt=n-5, next state TAIL.
REQ-019 TAIL: in_ready=hdr_ready=0; on adv, the output beat SHALL be data={160'b0,carry}, be masked to carry_cnt DW, byte=carry_cnt, sof=0, eof=1; the state SHALL return to IDLE.
REQ-020 in_sof=1 in BODY SHALL be treated as ordinary data (no restart); in_valid without in_sof in IDLE SHALL be held with in_ready=0.
REQ-021 Under out_ready=0 with out_valid=1, all state, carry and outputs SHALL be frozen; in_ready=hdr_ready=0.

Reset
REQ-022 On rstn=0 (async) or srst=1 (sync, priority over all other logic): state=IDLE; out_valid, out_sof, out_eof=0; out_byte=0; out_be=0; out_data=0; carry=0; carry_cnt=0.
REQ-023 Reset mid-packet SHALL discard the partial packet; the first post-reset output SHALL be a new sof beat.
REQ-024 hdr_ready and in_ready SHALL be 0 while rstn=0 or srst=1.

Verification
REQ-025 Header-only: hdr_nodata=1, hdr=96'hA -> one beat, sof=eof=1, out_byte=3, out_be=32'h00000FFF.
REQ-026 16-DW payload (two beats, second eof with in_byte=8) -> three beats, out_byte 8,8,3; eof on the third only.
REQ-027 Single beat, in_byte=5, eof -> one beat, sof=eof=1, out_byte=8, out_be=32'hFFFFFFFF; in_byte=1 -> out_byte=4, out_be=32'h0000FFFF.
REQ-028 Random out_ready backpressure over 100 packets of 1..64 DW -> payload DW sequence and DW count exactly preserved, with no dropped or duplicated beats.
REQ-029 srst asserted in BODY with out_valid=1 -> next cycle out_valid=0 and state IDLE; the following packet is emitted correctly from sof.

Source files
------------

// File: rtl/tx_tlp_header_insertion.sv
// Prepends a 3-DW TLP header to an NVMe payload stream, realigning payload DWs by 3 lanes.
// Latency: one cycle from an accepted header/data beat to out_valid (all outputs registered).
// Backpressure: out_ready=0 with out_valid=1 freezes everything; hdr_ready/in_ready drop to 0.
module tx_tlp_header_insertion #(
  parameter int PCIE_DATA_WIDTH = 256,
  parameter int NVME_DATA_WIDTH = 256
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       srst,
  input  logic                       hdr_valid,
  input  logic [95:0]                hdr_data,
  input  logic                       hdr_nodata,
  output logic                       hdr_ready,
  input  logic                       in_valid,
  input  logic                       in_sof,
  input  logic                       in_eof,
  input  logic [3:0]                 in_byte,
  input  logic [31:0]                in_be,
  input  logic [NVME_DATA_WIDTH-1:0] in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic                       out_sof,
  output logic                       out_eof,
  output logic [3:0]                 out_byte,
  output logic [31:0]                out_be,
  output logic [PCIE_DATA_WIDTH-1:0] out_data,
  input  logic                       out_ready
);

  typedef enum logic [1:0] {IDLE, BODY, TAIL} state_t;

  typedef struct packed {
    logic [95:0] dat;
    logic [11:0] be;
  } carry_t;

  state_t       state_q, state_d;
  carry_t       carry_q, carry_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         adv, run, take, emit;
  logic [95:0]  lo_dat;
  logic [11:0]  lo_be;
  logic [31:0]  be_full;
  logic         o_sof, o_eof;
  logic [3:0]   o_byte;
  logic [31:0]  o_be;
  logic [255:0] o_data;

  // Byte-enable mask covering the lowest k DWs of a beat.
  function automatic logic [31:0] dw_mask(input logic [3:0] k);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 8; i++)
      if (i < int'(k)) m[4*i +: 4] = 4'hF;
    return m;
  endfunction

  assign run = rstn & ~srst;
  assign adv = ~out_valid | out_ready;

  always_comb begin
    state_d   = state_q;
    carry_d   = carry_q;
    cnt_d     = cnt_q;
    hdr_ready = 1'b0;
    in_ready  = 1'b0;
    take      = 1'b0;
    emit      = 1'b0;
    lo_dat    = carry_q.dat;
    lo_be     = carry_q.be;
    be_full   = '0;
    o_sof     = 1'b0;
    o_eof     = 1'b0;
    o_byte    = '0;
    o_be      = '0;
    o_data    = '0;

    case (state_q)
      IDLE: begin
        if (hdr_nodata) begin
          hdr_ready = adv & run;
          if (hdr_valid & hdr_ready) begin
            emit   = 1'b1;
            o_data = {160'b0, hdr_data};
            o_be   = 32'h0000_0FFF;
            o_byte = 4'd3;
            o_sof  = 1'b1;
            o_eof  = 1'b1;
          end
        end else begin
          // Header and first data beat are only ever consumed together.
          hdr_ready = adv & run & hdr_valid & in_valid & in_sof;
          in_ready  = hdr_ready;
          if (hdr_ready) begin
            take   = 1'b1;
            lo_dat = hdr_data;
            lo_be  = 12'hFFF;
            o_sof  = 1'b1;
          end
        end
      end
      BODY: begin
        in_ready = adv & run;
        if (in_valid & in_ready) take = 1'b1;
      end
      TAIL: begin
        if (adv & run) begin
          emit    = 1'b1;
          o_data  = {160'b0, carry_q.dat};
          o_be    = {20'b0, carry_q.be} & dw_mask({2'b0, cnt_q});
          o_byte  = {2'b0, cnt_q};
          o_eof   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (take) begin
      emit    = 1'b1;
      o_data  = {in_data[159:0], lo_dat};
      be_full = {in_be[19:0], lo_be};
      carry_d = '{dat: in_data[255:160], be: in_be[31:20]};
      if (!in_eof) begin
        o_byte  = 4'd8;
        o_be    = be_full;
        state_d = BODY;
      end else if (in_byte <= 4'd5) begin
        o_byte  = in_byte + 4'd3;
        o_be    = be_full & dw_mask(in_byte + 4'd3);
        o_eof   = 1'b1;
        state_d = IDLE;
      end else begin
        // The last 1..3 payload DWs spill into a trailing beat.
        o_byte  = 4'd8;
        o_be    = be_full;
        cnt_d   = 2'(in_byte - 4'd5);
        state_d = TAIL;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      carry_q   <= '0;
      cnt_q     <= '0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
      out_byte  <= '0;
      out_be    <= '0;
      out_data  <= '0;
    end else if (srst) begin
      state_q   <= IDLE;
      carry_q   <= '0;
      cnt_q     <= '0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
      out_byte  <= '0;
      out_be    <= '0;
      out_data  <= '0;
    end else begin
      state_q <= state_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      if (adv) begin
        out_valid <= emit;
        out_sof   <= o_sof;
        out_eof   <= o_eof;
        out_byte  <= o_byte;
        out_be    <= o_be;
        out_data  <= o_data;
      end
    end
  end

endmodule

// File: tb/tb_tx_tlp_header_insertion.sv
// Bench for tx_tlp_header_insertion: directed and random packets scored against a DW-stream model.
// Latency: model is untimed; output beats are matched in order as they transfer.
// Backpressure: out_ready is randomised; the bench also inserts random input bubbles.
module tb_tx_tlp_header_insertion;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         srst = 1'b0;
  logic         hdr_valid = 1'b0;
  logic [95:0]  hdr_data = '0;
  logic         hdr_nodata = 1'b0;
  logic         hdr_ready;
  logic         in_valid = 1'b0;
  logic         in_sof = 1'b0;
  logic         in_eof = 1'b0;
  logic [3:0]   in_byte = 4'd8;
  logic [31:0]  in_be = '0;
  logic [255:0] in_data = '0;
  logic         in_ready;
  logic         out_valid, out_sof, out_eof;
  logic [3:0]   out_byte;
  logic [31:0]  out_be;
  logic [255:0] out_data;
  logic         out_ready = 1'b0;

  tx_tlp_header_insertion #(.PCIE_DATA_WIDTH(256), .NVME_DATA_WIDTH(256)) dut (
    .clk(clk), .rstn(rstn), .srst(srst),
    .hdr_valid(hdr_valid), .hdr_data(hdr_data), .hdr_nodata(hdr_nodata), .hdr_ready(hdr_ready),
    .in_valid(in_valid), .in_sof(in_sof), .in_eof(in_eof), .in_byte(in_byte),
    .in_be(in_be), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_sof(out_sof), .out_eof(out_eof), .out_byte(out_byte),
    .out_be(out_be), .out_data(out_data), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [255:0] dat;
    logic [31:0]  be;
    logic [3:0]   byt;
    logic         sof;
    logic         eof;
  } exp_t;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  logic [95:0] p_hdr[$];
  int          p_len[$];
  logic [31:0] pay_dw[$];
  logic [3:0]  pay_be[$];
  exp_t        exp_q[$];

  int pi, bi, po;
  bit hdr_done;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Model: output is the DW stream {header, payload} cut into 8-DW beats.
  task automatic add_packet(input logic [95:0] h, input int len, input bit rand_be);
    logic [31:0] s[$];
    logic [3:0]  sb[$];
    exp_t        e;
    int          n;
    p_hdr.push_back(h);
    p_len.push_back(len);
    for (int k = 0; k < 3; k++) begin
      s.push_back(h[32*k +: 32]);
      sb.push_back(4'hF);
    end
    for (int k = 0; k < len; k++) begin
      logic [31:0] d;
      logic [3:0]  b;
      d = $urandom;
      b = rand_be ? 4'($urandom_range(1, 15)) : 4'hF;
      pay_dw.push_back(d);
      pay_be.push_back(b);
      s.push_back(d);
      sb.push_back(b);
    end
    n = s.size();
    for (int b = 0; b * 8 < n; b++) begin
      e.dat = '0; e.be = '0; e.byt = '0;
      for (int k = 0; k < 8; k++) begin
        if (b * 8 + k < n) begin
          e.dat[32*k +: 32] = s[b*8+k];
          e.be[4*k +: 4]    = sb[b*8+k];
          e.byt++;
        end
      end
      e.sof = (b == 0);
      e.eof = ((b + 1) * 8 >= n);
      exp_q.push_back(e);
    end
  endtask

  task automatic reset_model();
    p_hdr.delete(); p_len.delete(); pay_dw.delete(); pay_be.delete(); exp_q.delete();
    pi = 0; bi = 0; po = 0; hdr_done = 0;
  endtask

  // One clock: drive at negedge, decide handshakes, then score after the edge.
  task automatic cycle(input int rdy_pct, input int gap_pct);
    bit   hs_hdr, hs_in, hs_out, gap;
    int   len, nb;
    exp_t e;
    logic [255:0] dmask;
    logic [255:0] obs_dat;
    logic [31:0]  obs_be;
    logic [3:0]   obs_byte;
    logic         obs_sof, obs_eof;
    @(negedge clk);
    out_ready = ($urandom_range(0, 99) < rdy_pct);
    gap = ($urandom_range(0, 99) < gap_pct);
    hdr_valid = 0; in_valid = 0; in_sof = 0; in_eof = 0; in_byte = 4'd8;
    len = 0; nb = 0;
    if (pi < p_hdr.size()) begin
      len = p_len[pi];
      nb  = (len + 7) / 8;
      hdr_valid  = !hdr_done && !gap;
      hdr_data   = p_hdr[pi];
      hdr_nodata = (len == 0);
      if (bi < nb && !gap) begin
        in_valid = 1;
        in_sof   = (bi == 0);
        in_eof   = (bi == nb - 1);
        in_byte  = in_eof ? 4'(len - 8 * bi) : 4'd8;
        for (int k = 0; k < 8; k++) begin
          if (8 * bi + k < len) begin
            in_data[32*k +: 32] = pay_dw[po + 8*bi + k];
            in_be[4*k +: 4]     = pay_be[po + 8*bi + k];
          end else begin
            in_data[32*k +: 32] = $urandom;
            in_be[4*k +: 4]     = 4'($urandom);
          end
        end
      end
    end
    #1;
    hs_hdr = hdr_valid & hdr_ready;
    hs_in  = in_valid & in_ready;
    hs_out = out_valid & out_ready;
    obs_dat = out_data; obs_be = out_be; obs_byte = out_byte;
    obs_sof = out_sof; obs_eof = out_eof;
    if (out_valid && !out_ready) chk("freeze_ready", {in_ready, hdr_ready}, 0);
    @(posedge clk);
    if (hs_out) begin
      if (exp_q.size() == 0) chk("unexpected_beat", 1, 0);
      else begin
        e = exp_q.pop_front();
        dmask = '0;
        for (int k = 0; k < 8; k++) if (k < int'(e.byt)) dmask[32*k +: 32] = '1;
        chk("out_byte", obs_byte, e.byt);
        chk("out_sof", obs_sof, e.sof);
        chk("out_eof", obs_eof, e.eof);
        chk("out_be", obs_be, e.be);
        chk("out_data", obs_dat & dmask, e.dat);
      end
    end
    if (hs_hdr) hdr_done = 1;
    if (hs_in) bi++;
    if (pi < p_hdr.size() && hdr_done && bi == nb) begin
      pi++; po += len; bi = 0; hdr_done = 0;
    end
  endtask

  task automatic run_all(input int rdy_pct, input int gap_pct, input int budget);
    int c;
    c = 0;
    while ((pi < p_hdr.size() || exp_q.size() > 0) && c < budget) begin
      cycle(rdy_pct, gap_pct);
      c++;
    end
    chk("drain_timeout", (c >= budget), 0);
  endtask

  initial begin
    reset_model();
    // Reset state with handshake-worthy inputs presented.
    hdr_valid = 1; hdr_nodata = 1; hdr_data = 96'hA; out_ready = 1;
    #12;
    chk("rst_hdr_ready", hdr_ready, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sof_eof", {out_sof, out_eof}, 0);
    chk("rst_out_byte", out_byte, 0);
    chk("rst_out_be", out_be, 0);
    chk("rst_out_data", out_data, 0);
    @(negedge clk);
    hdr_valid = 0;
    rstn = 1;

    // Data without sof in IDLE is held.
    @(negedge clk);
    hdr_valid = 1; hdr_nodata = 0; in_valid = 1; in_sof = 0; out_ready = 1;
    #1;
    chk("idle_nosof_in_ready", in_ready, 0);
    chk("idle_nosof_hdr_ready", hdr_ready, 0);
    @(negedge clk);
    hdr_valid = 0; in_valid = 0;

    // Directed: header-only, 16 DW, 5 DW, 1 DW, 6 DW, back-to-back.
    add_packet(96'hA, 0, 0);
    run_all(100, 0, 200);
    add_packet({32'h3, 32'h2, 32'h1}, 16, 0);
    run_all(100, 0, 200);
    add_packet({32'h13, 32'h12, 32'h11}, 5, 0);
    add_packet({32'h23, 32'h22, 32'h21}, 1, 0);
    add_packet({32'h33, 32'h32, 32'h31}, 6, 0);
    add_packet({32'h43, 32'h42, 32'h41}, 0, 0);
    run_all(100, 0, 400);

    // Random: 100 packets of 1..64 DW under backpressure and input bubbles.
    for (int i = 0; i < 100; i++)
      add_packet({$urandom, $urandom, $urandom}, $urandom_range(1, 64), 1);
    run_all(60, 20, 20000);

    // Synchronous reset in BODY with a stalled output beat.
    reset_model();
    add_packet({32'h53, 32'h52, 32'h51}, 16, 0);
    cycle(100, 0);
    cycle(0, 0);
    @(negedge clk);
    srst = 1; hdr_valid = 0; in_valid = 0; out_ready = 0;
    #1;
    chk("srst_pre_out_valid", out_valid, 1);
    chk("srst_hdr_ready", hdr_ready, 0);
    chk("srst_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    chk("srst_out_valid", out_valid, 0);
    chk("srst_out_sof", out_sof, 0);
    chk("srst_out_data", out_data, 0);
    @(negedge clk);
    srst = 0;
    reset_model();
    add_packet({32'h63, 32'h62, 32'h61}, 10, 1);
    run_all(70, 10, 400);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
